// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the fetch-stage PC sequencer.
//   pc_state_t  - fetch FSM states (IDLE, FETCH, HOLD)
//   RESET_PC    - PC value loaded on reset
//   EXC_PC      - PC value loaded on an alignment exception
//                 (only used when PC_ALIGN_CHECK_EN is defined)
//   WORD_SHIFT  - byte-to-word scaling for branch/jump offsets
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC     = 32'hBFC0_0380;
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/branch_target.sv
// branch_target: combinational branch/jump target calculation.
// Ports:
//   br_base     in  32  PC+4 of the branch/jump instruction
//   br_imm      in  16  signed word offset of a conditional branch
//   jump_index  in  26  instr_index field of j/jal
//   br_target   out 32  br_base + sign-extended offset scaled to bytes
//   jump_target out 32  br_base[31:28] concatenated with scaled index
module branch_target
    import pipeline_pkg::*;
(
    input  logic [31:0] br_base,
    input  logic [15:0] br_imm,
    input  logic [25:0] jump_index,
    output logic [31:0] br_target,
    output logic [31:0] jump_target
);

    logic [31:0] imm_sext;

    always_comb begin
        imm_sext    = {{16{br_imm[15]}}, br_imm};
        // Add wraps modulo 2^32; no overflow detection.
        br_target   = br_base + (imm_sext << WORD_SHIFT);
        jump_target = {br_base[31:28], jump_index, {WORD_SHIFT{1'b0}}};
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
// Owns the PC register and issues imem fetch requests with a req/ack
// handshake. Next PC priority: redirect this cycle (jr > jump > branch),
// then a pending redirect, then pc_o + 4.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   - misaligned target traps to EXC_PC with exc_o/badvaddr_o
//   undefined - target[1:0] forced to 2'b00, exc_o/badvaddr_o tied 0
// Ports:
//   clk         in   1  clock, posedge
//   rst         in   1  synchronous active-high reset
//   stall       in   1  hazard hold; PC does not advance
//   br_taken    in   1  conditional branch resolved taken
//   br_base     in  32  PC+4 of the branch/jump instruction
//   br_imm      in  16  branch immediate (signed word offset)
//   jump        in   1  j/jal
//   jump_index  in  26  instr_index field
//   jr          in   1  jr/jalr
//   jr_target   in  32  register target for jr
//   inst_ack    in   1  imem accepted pc_o
//   pc_o        out 32  current fetch address
//   inst_req    out  1  fetch request valid
//   flush_o     out  1  pulse when pc_o takes a redirect target
//   exc_o       out  1  alignment exception pulse
//   badvaddr_o  out 32  faulting target of the last exception
module pc_sequencer
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [15:0] br_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        inst_ack,
    output logic [31:0] pc_o,
    output logic        inst_req,
    output logic        flush_o,
    output logic        exc_o,
    output logic [31:0] badvaddr_o
);

    pc_state_t   state;
    pc_state_t   state_nxt;

    logic [31:0] br_target;
    logic [31:0] jump_target;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        advance;
    logic        sel_vld;
    logic [31:0] sel_pc;

    logic [31:0] pc_q;
    logic [31:0] pending_pc;
    logic        pending_vld;
    logic        flush_q;

    branch_target u_branch_target (
        .br_base     (br_base),
        .br_imm      (br_imm),
        .jump_index  (jump_index),
        .br_target   (br_target),
        .jump_target (jump_target)
    );

    // Redirect selection and advance condition.
    always_comb begin
        redirect    = jr | jump | br_taken;
        redirect_pc = br_target;
        if (jr) begin
            redirect_pc = jr_target;
        end else if (jump) begin
            redirect_pc = jump_target;
        end
        advance = ((state == FETCH) && inst_ack && !stall) ||
                  ((state == HOLD) && !stall);
        sel_vld = redirect | pending_vld;
        sel_pc  = redirect ? redirect_pc : pending_pc;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (inst_ack) begin
                    state_nxt = stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic        exc_q;
    logic [31:0] badvaddr_q;
    logic        misaligned;

    always_comb begin
        misaligned = (sel_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pending_pc  <= '0;
            pending_vld <= 1'b0;
            flush_q     <= 1'b0;
            exc_q       <= 1'b0;
            badvaddr_q  <= '0;
        end else begin
            flush_q <= 1'b0;
            exc_q   <= 1'b0;
            if (advance) begin
                pending_vld <= 1'b0;
                if (sel_vld) begin
                    flush_q <= 1'b1;
                    if (misaligned) begin
                        pc_q       <= EXC_PC;
                        exc_q      <= 1'b1;
                        badvaddr_q <= sel_pc;
                    end else begin
                        pc_q <= sel_pc;
                    end
                end else begin
                    pc_q <= pc_q + 32'd4;
                end
            end else if (redirect) begin
                // Newest redirect wins; alignment is checked when applied.
                pending_pc  <= redirect_pc;
                pending_vld <= 1'b1;
            end
        end
    end

    assign exc_o      = exc_q;
    assign badvaddr_o = badvaddr_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pending_pc  <= '0;
            pending_vld <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (advance) begin
                pending_vld <= 1'b0;
                if (sel_vld) begin
                    flush_q <= 1'b1;
                    pc_q    <= {sel_pc[31:2], 2'b00};
                end else begin
                    pc_q <= pc_q + 32'd4;
                end
            end else if (redirect) begin
                pending_pc  <= redirect_pc;
                pending_vld <= 1'b1;
            end
        end
    end

    assign exc_o      = 1'b0;
    assign badvaddr_o = '0;
`endif

    assign pc_o     = pc_q;
    assign inst_req = (state == FETCH);
    assign flush_o  = flush_q;

endmodule
